// File: rtl/vp_controller.sv
// Load-value speculation controller for MEM-stage D-cache misses.
// Last-value table with saturating confidence, predict/verify/recover FSM.
module vp_controller #(
    parameter int INDEX_WIDTH = 6,
    parameter int CONF_BITS   = 2,
    parameter int CONF_THRESH = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vp_en,
    input  logic                  load_req_valid,
    output logic                  load_req_ready,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  stall,
    output logic                  pred_valid,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  commit,
    output logic                  recover_req,
    input  logic                  recover_ack,
    output logic [15:0]           num_pred,
    output logic [15:0]           num_mispred
);

    localparam int ENTRIES = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        STALL_WAIT,
        SPEC_WAIT,
        RECOVER
    } state_t;

    state_t state;

    logic [DATA_WIDTH-1:0]  lvt_val  [ENTRIES];
    logic [CONF_BITS-1:0]   lvt_conf [ENTRIES];
    logic [ENTRIES-1:0]     lvt_vld;

    logic [INDEX_WIDTH-1:0] idx;
    logic [INDEX_WIDTH-1:0] lat_idx;
    logic [DATA_WIDTH-1:0]  lat_val;
    logic                   hit;
    logic                   idle;
    logic                   unused_pc;

    assign idx       = load_pc[INDEX_WIDTH+1:2];
    assign unused_pc = ^{load_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], load_pc[1:0]};
    assign idle      = (state == IDLE);

    assign hit = lvt_vld[idx] && vp_en &&
                 (lvt_conf[idx] >= CONF_BITS'(CONF_THRESH));

    assign load_req_ready = idle;

    // Miss stall must be visible in the acceptance cycle itself.
    assign stall = (state == STALL_WAIT) ||
                   (idle && load_req_valid && !hit);

    function automatic logic [CONF_BITS-1:0] conf_inc(
        input logic [CONF_BITS-1:0] c
    );
        return (&c) ? c : c + CONF_BITS'(1);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (&c) ? c : c + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pred_valid  <= 1'b0;
            data_valid  <= 1'b0;
            commit      <= 1'b0;
            recover_req <= 1'b0;
            data_out    <= '0;
            num_pred    <= '0;
            num_mispred <= '0;
            lat_idx     <= '0;
            lat_val     <= '0;
            lvt_vld     <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                lvt_val[i]  <= '0;
                lvt_conf[i] <= '0;
            end
        end else begin
            pred_valid <= 1'b0;
            data_valid <= 1'b0;
            commit     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_req_valid) begin
                        lat_idx <= idx;
                        if (hit) begin
                            lat_val    <= lvt_val[idx];
                            data_out   <= lvt_val[idx];
                            pred_valid <= 1'b1;
                            num_pred   <= sat_inc(num_pred);
                            state      <= SPEC_WAIT;
                        end else begin
                            state <= STALL_WAIT;
                        end
                    end
                end
                STALL_WAIT: begin
                    if (mem_resp_valid) begin
                        data_out   <= mem_resp_data;
                        data_valid <= 1'b1;
                        state      <= IDLE;
                        if (lvt_vld[lat_idx] &&
                            lvt_val[lat_idx] == mem_resp_data) begin
                            lvt_conf[lat_idx] <= conf_inc(lvt_conf[lat_idx]);
                        end else begin
                            lvt_val[lat_idx]  <= mem_resp_data;
                            lvt_vld[lat_idx]  <= 1'b1;
                            lvt_conf[lat_idx] <= '0;
                        end
                    end
                end
                SPEC_WAIT: begin
                    if (mem_resp_valid) begin
                        if (mem_resp_data == lat_val) begin
                            commit            <= 1'b1;
                            lvt_conf[lat_idx] <= conf_inc(lvt_conf[lat_idx]);
                            state             <= IDLE;
                        end else begin
                            recover_req       <= 1'b1;
                            data_out          <= mem_resp_data;
                            lvt_val[lat_idx]  <= mem_resp_data;
                            lvt_vld[lat_idx]  <= 1'b1;
                            lvt_conf[lat_idx] <= '0;
                            num_mispred       <= sat_inc(num_mispred);
                            state             <= RECOVER;
                        end
                    end
                end
                RECOVER: begin
                    if (recover_ack) begin
                        recover_req <= 1'b0;
                        data_valid  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vp_controller.sv
// Directed bench for vp_controller with an output-event scoreboard.
module tb_vp_controller;

    localparam int K_PRED = 0;
    localparam int K_COMMIT = 1;
    localparam int K_RECOV = 2;
    localparam int K_DVAL = 3;

    typedef struct {
        int          k;
        logic [31:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vp_en;
    logic        load_req_valid;
    logic        load_req_ready;
    logic [31:0] load_pc;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        stall;
    logic        pred_valid;
    logic        data_valid;
    logic [31:0] data_out;
    logic        commit;
    logic        recover_req;
    logic        recover_ack;
    logic [15:0] num_pred;
    logic [15:0] num_mispred;

    int   tests = 0;
    int   fails = 0;
    int   exp_np = 0;
    int   exp_nm = 0;
    ev_t  q[$];
    logic rr_q = 1'b0;

    vp_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vp_en         (vp_en),
        .load_req_valid(load_req_valid),
        .load_req_ready(load_req_ready),
        .load_pc       (load_pc),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .stall         (stall),
        .pred_valid    (pred_valid),
        .data_valid    (data_valid),
        .data_out      (data_out),
        .commit        (commit),
        .recover_req   (recover_req),
        .recover_ack   (recover_ack),
        .num_pred      (num_pred),
        .num_mispred   (num_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", n, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d);
        ev_t e;
        e.k = k;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic got(input int k, input logic [31:0] d);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $error("FAIL unexpected_event: got kind %0d data %h expected none",
                   k, d);
        end else begin
            e = q.pop_front();
            assert (e.k == k && e.d === d) else begin
                fails++;
                $error("FAIL event: got kind %0d data %h expected kind %0d data %h",
                       k, d, e.k, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pred_valid) got(K_PRED, data_out);
            if (commit) got(K_COMMIT, 32'h0);
            if (recover_req && !rr_q) got(K_RECOV, data_out);
            if (data_valid) got(K_DVAL, data_out);
        end
        rr_q = recover_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One load: request, response after a short gap, optional recovery.
    task automatic load(input logic [31:0] pc, input logic [31:0] resp,
                        input bit hit, input logic [31:0] pv, input bit en);
        bit mis;
        mis = hit && (pv != resp);
        if (hit) begin
            push(K_PRED, pv);
            exp_np++;
            if (mis) begin
                push(K_RECOV, resp);
                push(K_DVAL, resp);
                exp_nm++;
            end else begin
                push(K_COMMIT, 32'h0);
            end
        end else begin
            push(K_DVAL, resp);
        end
        vp_en = en;
        load_req_valid = 1'b1;
        load_pc = pc;
        #1;
        chk("ready_idle", {31'b0, load_req_ready}, 32'd1);
        chk("stall_accept", {31'b0, stall}, {31'b0, !hit});
        step();
        load_req_valid = 1'b0;
        chk("stall_wait", {31'b0, stall}, {31'b0, !hit});
        step();
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data = resp;
        #1;
        chk("stall_resp", {31'b0, stall}, {31'b0, !hit});
        step();
        mem_resp_valid = 1'b0;
        if (mis) begin
            chk("recover_req", {31'b0, recover_req}, 32'd1);
            chk("recover_data", data_out, resp);
            chk("ready_recover", {31'b0, load_req_ready}, 32'd0);
            step();
            chk("recover_hold", data_out, resp);
            step();
            recover_ack = 1'b1;
            step();
            recover_ack = 1'b0;
            chk("recover_drop", {31'b0, recover_req}, 32'd0);
        end else begin
            chk("stall_drop", {31'b0, stall}, 32'd0);
        end
        step();
        chk("events_drained", q.size(), 32'd0);
        chk("ready_back", {31'b0, load_req_ready}, 32'd1);
    endtask

    task automatic counters(input string n);
        chk({n, "_num_pred"}, {16'b0, num_pred}, exp_np);
        chk({n, "_num_mispred"}, {16'b0, num_mispred}, exp_nm);
    endtask

    initial begin
        rst_n = 1'b0;
        vp_en = 1'b1;
        load_req_valid = 1'b0;
        load_pc = '0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        recover_ack = 1'b0;
        #12;
        chk("rst_ready", {31'b0, load_req_ready}, 32'd1);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_pulses", {29'b0, pred_valid, data_valid, commit}, 32'd0);
        chk("rst_recover", {31'b0, recover_req}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        counters("rst");
        rst_n = 1'b1;
        step();

        // Stray response and ack while idle produce nothing.
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hDEAD;
        recover_ack = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        recover_ack = 1'b0;
        step();
        chk("idle_ignore", q.size(), 32'd0);

        // Cold miss, then training to a prediction.
        load(32'h40, 32'h1234, 0, 0, 1);
        load(32'h40, 32'h1234, 0, 0, 1);
        load(32'h40, 32'h1234, 0, 0, 1);
        load(32'h40, 32'h1234, 1, 32'h1234, 1);
        counters("train");

        // Mispredict at conf 3; entry restarts at conf 0.
        load(32'h40, 32'h5678, 1, 32'h1234, 1);
        counters("mispred");
        load(32'h40, 32'h5678, 0, 0, 1);
        load(32'h40, 32'h5678, 0, 0, 1);
        load(32'h40, 32'h5678, 1, 32'h5678, 1);

        // Prediction disabled at conf 3; conf stays saturated.
        load(32'h40, 32'h5678, 0, 0, 0);
        load(32'h40, 32'h5678, 1, 32'h5678, 1);
        counters("vp_en");

        // Aliasing: 0x140 overwrites the 0x40 entry.
        load(32'h40, 32'hAAAA, 1, 32'h5678, 1);
        load(32'h140, 32'hBBBB, 0, 0, 1);
        load(32'h40, 32'hBBBB, 0, 0, 1);
        load(32'h40, 32'hBBBB, 0, 0, 1);
        counters("alias");

        // Reset while waiting on a speculative response.
        push(K_PRED, 32'hBBBB);
        load_req_valid = 1'b1;
        load_pc = 32'h40;
        #1;
        chk("spec_stall", {31'b0, stall}, 32'd0);
        step();
        load_req_valid = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        exp_np = 0;
        exp_nm = 0;
        chk("async_ready", {31'b0, load_req_ready}, 32'd1);
        chk("async_stall", {31'b0, stall}, 32'd0);
        chk("async_pulses", {29'b0, pred_valid, data_valid, commit}, 32'd0);
        chk("async_recover", {31'b0, recover_req}, 32'd0);
        chk("async_data", data_out, 32'd0);
        counters("async");
        step();
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hBBBB;
        step();
        mem_resp_valid = 1'b0;
        step();
        chk("late_resp", q.size(), 32'd0);
        load(32'h40, 32'h1111, 0, 0, 1);
        counters("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
